// File: rtl/ttt2_bist_pkg.sv
// Shared types and constants for the ttt2 BIST controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ttt2_bist_pkg;

    localparam int VEC_W_DEF  = 24;
    localparam int RESP_W_DEF = 21;

    // Pattern LFSR feedback taps: x^24+x^23+x^22+x^17+1 -> bits 23,22,21,16.
    localparam logic [23:0] LFSR_POLY_TAPS = 24'hE1_0000;

    // Signature register polynomial x^21+x^2+1 (Galois, x^21 term implicit).
    localparam logic [20:0] MISR_POLY = 21'h000005;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_FLUSH,
        ST_CMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ttt2_misr.sv
// Multiple-input signature register: compacts one parallel response word per enabled cycle.
// Latency: absorbed response is visible on sig one cycle after it is presented.
// Backpressure: none; absorbs whenever en is high, load has priority over en.
//
// Ports: clk/rst_n (async active-low), load + seed (synchronous seed load),
//        en + resp (parallel response input), sig (current signature).
module ttt2_misr
    import ttt2_bist_pkg::*;
#(
    parameter int             W    = RESP_W_DEF,
    parameter logic [W-1:0]   POLY = MISR_POLY
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  seed,
    input  logic          en,
    input  logic [W-1:0]  resp,
    output logic [W-1:0]  sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ resp;
        end
    end

endmodule

// File: rtl/ttt2_bist_ctrl.sv
// BIST controller for the ttt2 netlist: LFSR patterns out, MISR-compacted responses in, golden compare.
// Latency: start to done_pad = N_PAT+2 cycles (N_PAT+3 with TTT2_BIST_PIPE_EN defined).
// Backpressure: none; start_pad is sampled only in IDLE/DONE and ignored while busy.
//
// Ports: clk_pad, rst_n_pad (async active-low), start_pad (run request),
//        vec_pad (pattern to netlist), resp_pad (netlist outputs),
//        busy_pad / done_pad / pass_pad (status), sig_pad (current signature).
// Optional macro TTT2_BIST_PIPE_EN: registers resp_pad before the MISR and adds a FLUSH state.
module ttt2_bist_ctrl
    import ttt2_bist_pkg::*;
#(
    parameter int                 VEC_W      = VEC_W_DEF,
    parameter int                 RESP_W     = RESP_W_DEF,
    parameter int                 N_PAT      = 1024,
    parameter logic [VEC_W-1:0]   LFSR_SEED  = 24'h000001,
    parameter logic [RESP_W-1:0]  MISR_SEED  = 21'h000000,
    parameter logic [RESP_W-1:0]  GOLDEN_SIG = 21'h000000
) (
    input  logic               clk_pad,
    input  logic               rst_n_pad,
    input  logic               start_pad,
    output logic [VEC_W-1:0]   vec_pad,
    input  logic [RESP_W-1:0]  resp_pad,
    output logic               busy_pad,
    output logic               done_pad,
    output logic               pass_pad,
    output logic [RESP_W-1:0]  sig_pad
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [VEC_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? VEC_W'(1) : LFSR_SEED;
    localparam logic [15:0]      LAST_CNT  = 16'(N_PAT - 1);

    state_t             state;
    logic [VEC_W-1:0]   lfsr;
    logic [VEC_W-1:0]   lfsr_next;
    logic [15:0]        cnt;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    logic               misr_load;
    logic               misr_en;
    logic [RESP_W-1:0]  misr_in;
    logic [RESP_W-1:0]  misr_sig;

    assign lfsr_next = {lfsr[VEC_W-2:0], ^(lfsr & VEC_W'(LFSR_POLY_TAPS))};
    assign misr_load = (state == ST_SEED);

`ifdef TTT2_BIST_PIPE_EN
    // One register stage on the response path; resp_vld_q marks which
    // cycles carry a real response (the first RUN cycle sees a bubble).
    logic [RESP_W-1:0] resp_q;
    logic              resp_vld_q;

    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            resp_q     <= '0;
            resp_vld_q <= 1'b0;
        end else begin
            resp_q     <= resp_pad;
            resp_vld_q <= (state == ST_RUN);
        end
    end

    assign misr_en = resp_vld_q;
    assign misr_in = resp_q;
`else
    assign misr_en = (state == ST_RUN);
    assign misr_in = resp_pad;
`endif

    ttt2_misr #(
        .W    (RESP_W),
        .POLY (RESP_W'(MISR_POLY))
    ) u_misr (
        .clk   (clk_pad),
        .rst_n (rst_n_pad),
        .load  (misr_load),
        .seed  (MISR_SEED),
        .en    (misr_en),
        .resp  (misr_in),
        .sig   (misr_sig)
    );

    // The LFSR register doubles as the vec_pad driver: it is loaded on entry
    // to RUN and cleared on entry to CMP, so vec_pad is zero everywhere else.
    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            state  <= ST_IDLE;
            lfsr   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pad) begin
                        state  <= ST_SEED;
                        busy_q <= 1'b1;
                    end
                end
                ST_SEED: begin
                    state  <= ST_RUN;
                    lfsr   <= LFSR_INIT;
                    cnt    <= '0;
                    pass_q <= 1'b0;
                end
                ST_RUN: begin
                    if (cnt == LAST_CNT) begin
`ifdef TTT2_BIST_PIPE_EN
                        // Hold the last pattern so FLUSH keeps driving it.
                        state <= ST_FLUSH;
`else
                        state <= ST_CMP;
                        lfsr  <= '0;
`endif
                    end else begin
                        lfsr <= lfsr_next;
                        cnt  <= cnt + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_CMP;
                    lfsr  <= '0;
                end
                ST_CMP: begin
                    state  <= ST_DONE;
                    pass_q <= (misr_sig == GOLDEN_SIG);
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                ST_DONE: begin
                    if (start_pad) begin
                        state  <= ST_SEED;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    lfsr   <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign vec_pad  = lfsr;
    assign busy_pad = busy_q;
    assign done_pad = done_q;
    assign pass_pad = pass_q;
    assign sig_pad  = misr_sig;

endmodule

// File: tb/tb_ttt2_bist_ctrl.sv
// Scoreboard bench for ttt2_bist_ctrl: two instances (16 patterns, zero seed;
// 2 patterns, golden 3) driven by a behavioural stand-in netlist.
// Expected patterns/signatures are queued at start; a monitor pops and compares.
module tb_ttt2_bist_ctrl;

    localparam int NA = 16;
    localparam int NB = 2;
`ifdef TTT2_BIST_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic [20:0] sig;
        logic        pass;
        logic [15:0] lat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] vec_o  [2];
    logic [20:0] resp_i [2];
    logic [20:0] sig_o  [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];

    int          mode = 0;
    logic [20:0] key  = '0;

    int          checks = 0;
    int          errors = 0;
    int          pcyc = 0;
    int          issued    [2];
    int          completed [2];
    int          start_p   [2];
    logic [23:0] vq [2][$];
    res_t        rq [2][$];

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        pcyc++;
    end

    // Stand-in combinational netlist: zero, constant 1, or a keyed mix of the pattern.
    function automatic logic [20:0] netlist(input logic [23:0] v, input int m, input logic [20:0] k);
        case (m)
            0:       return 21'h0;
            1:       return 21'h1;
            default: return (v[20:0] ^ k) ^ ({v[23:21], v[17:0]} & {v[5:0], v[23:9]});
        endcase
    endfunction

    assign resp_i[0] = netlist(vec_o[0], mode, key);
    assign resp_i[1] = netlist(vec_o[1], mode, key);

    ttt2_bist_ctrl #(
        .N_PAT(NA), .LFSR_SEED(24'h000000), .MISR_SEED(21'h0), .GOLDEN_SIG(21'h0)
    ) dut_a (
        .clk_pad(clk), .rst_n_pad(rst_n), .start_pad(start),
        .vec_pad(vec_o[0]), .resp_pad(resp_i[0]), .busy_pad(busy_o[0]),
        .done_pad(done_o[0]), .pass_pad(pass_o[0]), .sig_pad(sig_o[0])
    );

    ttt2_bist_ctrl #(
        .N_PAT(NB), .LFSR_SEED(24'h000001), .MISR_SEED(21'h0), .GOLDEN_SIG(21'h000003)
    ) dut_b (
        .clk_pad(clk), .rst_n_pad(rst_n), .start_pad(start),
        .vec_pad(vec_o[1]), .resp_pad(resp_i[1]), .busy_pad(busy_o[1]),
        .done_pad(done_o[1]), .pass_pad(pass_o[1]), .sig_pad(sig_o[1])
    );

    function automatic int npat_of(input int i);
        return (i == 0) ? NA : NB;
    endfunction
    function automatic logic [23:0] seed_of(input int i);
        return (i == 0) ? 24'h000000 : 24'h000001;
    endfunction
    function automatic logic [20:0] gold_of(input int i);
        return (i == 0) ? 21'h000000 : 21'h000003;
    endfunction

    function automatic logic [23:0] lfsr_step(input logic [23:0] l);
        return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
    endfunction
    function automatic logic [20:0] misr_step(input logic [20:0] m, input logic [20:0] r);
        return {m[19:0], 1'b0} ^ (m[20] ? 21'h000005 : 21'h0) ^ r;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", name, i, act, exp);
        end
    endtask

    // Reference: list the patterns, fold the netlist responses into a signature.
    task automatic push_expect(input int i);
        logic [23:0] l;
        logic [20:0] m;
        res_t        r;
        l = seed_of(i);
        if (l == 24'h0) l = 24'h1;
        m = 21'h0;
        for (int k = 0; k < npat_of(i); k++) begin
            vq[i].push_back(l);
            m = misr_step(m, netlist(l, mode, key));
            l = lfsr_step(l);
        end
`ifdef TTT2_BIST_PIPE_EN
        vq[i].push_back(vq[i][$]);
`endif
        r.sig  = m;
        r.pass = (m == gold_of(i));
        r.lat  = 16'(npat_of(i) + 2 + EXTRA);
        rq[i].push_back(r);
    endtask

    function automatic bit pending();
        return (issued[0] != completed[0]) || (issued[1] != completed[1]);
    endfunction

    task automatic begin_run(input int m, input logic [20:0] k);
        @(negedge clk);
        mode = m;
        key  = k;
        for (int i = 0; i < 2; i++) begin
            push_expect(i);
            start_p[i] = pcyc;
            issued[i]++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int m, input logic [20:0] k, input bit poke);
        int t;
        begin_run(m, k);
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (pending() && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("run_timeout", 0, 32'(pending()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_vec"},  i, 32'(vec_o[i]),  32'd0);
            chk({tag, "_busy"}, i, 32'(busy_o[i]), 32'd0);
            chk({tag, "_done"}, i, 32'(done_o[i]), 32'd0);
            chk({tag, "_pass"}, i, 32'(pass_o[i]), 32'd0);
            chk({tag, "_sig"},  i, 32'(sig_o[i]),  32'd0);
        end
    endtask

    // Monitor: compares every presented pattern and every completed run.
    initial begin
        bit   prev_done [2];
        res_t r;
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    vq[i].delete();
                    rq[i].delete();
                    completed[i] = issued[i];
                    prev_done[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (!busy_o[i]) begin
                        chk("vec_idle_zero", i, 32'(vec_o[i]), 32'd0);
                    end else if (vec_o[i] != 24'h0) begin
                        if (vq[i].size() == 0) chk("vec_unexpected", i, 32'(vec_o[i]), 32'd0);
                        else chk("vec_pattern", i, 32'(vec_o[i]), 32'(vq[i].pop_front()));
                    end
                    chk("busy_done_excl", i, 32'(busy_o[i] & done_o[i]), 32'd0);
                    if (done_o[i] && !prev_done[i]) begin
                        if (rq[i].size() == 0) begin
                            chk("done_unexpected", i, 32'd1, 32'd0);
                        end else begin
                            r = rq[i].pop_front();
                            chk("sig", i, 32'(sig_o[i]), 32'(r.sig));
                            chk("pass", i, 32'(pass_o[i]), 32'(r.pass));
                            chk("latency", i, 32'(pcyc - start_p[i] - 1), 32'(r.lat));
                            chk("patterns_left", i, 32'(vq[i].size()), 32'd0);
                            vq[i].delete();
                        end
                        completed[i]++;
                    end
                    prev_done[i] = done_o[i];
                end
            end
        end
    end

    initial begin
        issued[0] = 0;  issued[1] = 0;
        completed[0] = 0; completed[1] = 0;
        start_p[0] = 0; start_p[1] = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run(0, 21'h0, 1'b0);                   // all-zero responses
        run(1, 21'h0, 1'b0);                   // constant response 1 (dut_b: sig 3, pass)
        run(2, 21'($urandom), 1'b0);
        run(2, 21'($urandom), 1'b1);           // start pulsed mid-run
        run(2, 21'($urandom), 1'b0);

        // Reset during RUN cycle 3 of dut_a: outputs must clear without a clock edge.
        begin_run(2, 21'($urandom));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(2, 21'($urandom), 1'b0);
        run(1, 21'h0, 1'b1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
